// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: one-hot state encoding and
// default cycle constants used by reset_sequencer.
package rst_seq_pkg;

  typedef enum logic [5:0] {
    ST_ASSERT_DCM = 6'b000001,
    ST_WAIT_LOCK  = 6'b000010,
    ST_SETTLE     = 6'b000100,
    ST_RELEASE    = 6'b001000,
    ST_RUN        = 6'b010000,
    ST_FAIL       = 6'b100000
  } state_t;

  localparam int DEF_NUM_DCM             = 1;
  localparam int DEF_NUM_DOMAINS         = 4;
  localparam int DEF_CNT_W               = 16;
  localparam int DEF_DCM_RST_CYCLES      = 10000;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_LOCK_SETTLE_CYCLES  = 5000;
  localparam int DEF_STAGGER_CYCLES      = 100;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous level signals into
// the CLK domain; every bit is synchronised independently.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  logic [W-1:0] meta;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta <= '0;
      Q    <= '0;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / forced reset sequencer: pulses DCM_RST, waits for lock with bounded
// retries, settles, then releases the domain resets in ascending order.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DCM             = DEF_NUM_DCM,
  parameter int NUM_DOMAINS         = DEF_NUM_DOMAINS,
  parameter int CNT_W               = DEF_CNT_W,
  parameter int DCM_RST_CYCLES      = DEF_DCM_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int LOCK_SETTLE_CYCLES  = DEF_LOCK_SETTLE_CYCLES,
  parameter int STAGGER_CYCLES      = DEF_STAGGER_CYCLES
) (
  input  logic                   CLK,
  input  logic                   FORCE_RST_N,
  input  logic                   SOFT_RST,
  input  logic [NUM_DCM-1:0]     DCM_LOCKED,
  output logic                   DCM_RST,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RST,
  output logic                   LOCK_FAIL,
  output logic                   SEQ_DONE,
  output state_t                 STATE_DBG
);

  localparam int IDX_W   = $clog2(NUM_DOMAINS + 1);
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]       DCM_LOAD     = CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]       TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]       SETTLE_LOAD  = CNT_W'(LOCK_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]       STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]       LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [RETRY_W-1:0]     MAX_R        = RETRY_W'(MAX_RETRIES);
  localparam logic [NUM_DOMAINS-1:0] ALL1         = '1;
  localparam bit                     ALL_AT_ONCE  = (STAGGER_CYCLES == 0) || (NUM_DOMAINS == 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [RETRY_W-1:0] retry;
  logic [NUM_DCM-1:0] locked_sync;
  logic               lock_ok;
  logic               state_legal;

  sync_2ff #(.W(NUM_DCM)) u_lock_sync (
    .CLK   (CLK),
    .RST_N (FORCE_RST_N),
    .D     (DCM_LOCKED),
    .Q     (locked_sync)
  );

  assign lock_ok   = &locked_sync;
  assign STATE_DBG = state;

  always_comb begin
    state_legal = 1'b0;
    case (state)
      ST_ASSERT_DCM, ST_WAIT_LOCK, ST_SETTLE,
      ST_RELEASE, ST_RUN, ST_FAIL: state_legal = 1'b1;
      default:                     state_legal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge FORCE_RST_N) begin
    if (!FORCE_RST_N) begin
      state      <= ST_ASSERT_DCM;
      cnt        <= DCM_LOAD;
      idx        <= '0;
      retry      <= '0;
      DCM_RST    <= 1'b1;
      DOMAIN_RST <= ALL1;
      LOCK_FAIL  <= 1'b0;
      SEQ_DONE   <= 1'b0;
    end else if (SOFT_RST || !state_legal) begin
      // Restart from a fresh DCM pulse; also the recovery path for a corrupted state.
      state      <= ST_ASSERT_DCM;
      cnt        <= DCM_LOAD;
      idx        <= '0;
      retry      <= '0;
      DCM_RST    <= 1'b1;
      DOMAIN_RST <= ALL1;
      LOCK_FAIL  <= 1'b0;
      SEQ_DONE   <= 1'b0;
    end else begin
      case (state)
        ST_ASSERT_DCM: begin
          if (cnt == '0) begin
            state   <= ST_WAIT_LOCK;
            DCM_RST <= 1'b0;
            cnt     <= TIMEOUT_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_ok) begin
            state <= ST_SETTLE;
            cnt   <= SETTLE_LOAD;
          end else if (cnt == '0) begin
            if (retry < MAX_R) begin
              retry   <= retry + 1'b1;
              state   <= ST_ASSERT_DCM;
              DCM_RST <= 1'b1;
              cnt     <= DCM_LOAD;
            end else begin
              state     <= ST_FAIL;
              LOCK_FAIL <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!lock_ok) begin
            state      <= ST_WAIT_LOCK;
            cnt        <= TIMEOUT_LOAD;
            DOMAIN_RST <= ALL1;
          end else if (cnt == '0) begin
            if (ALL_AT_ONCE) begin
              state      <= ST_RUN;
              DOMAIN_RST <= '0;
              SEQ_DONE   <= 1'b1;
              retry      <= '0;
            end else begin
              state      <= ST_RELEASE;
              DOMAIN_RST <= ALL1 << 1;
              idx        <= IDX_W'(1);
              cnt        <= STAGGER_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!lock_ok) begin
            state      <= ST_WAIT_LOCK;
            cnt        <= TIMEOUT_LOAD;
            DOMAIN_RST <= ALL1;
          end else if (cnt == '0) begin
            // Releases are strictly ascending, so bits idx and below are all clear.
            DOMAIN_RST <= ALL1 << (idx + 1'b1);
            if (idx == LAST_IDX) begin
              state    <= ST_RUN;
              SEQ_DONE <= 1'b1;
              retry    <= '0;
            end else begin
              idx <= idx + 1'b1;
              cnt <= STAGGER_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_ok) begin
            state      <= ST_ASSERT_DCM;
            cnt        <= DCM_LOAD;
            DCM_RST    <= 1'b1;
            DOMAIN_RST <= ALL1;
            SEQ_DONE   <= 1'b0;
          end
        end
        ST_FAIL: begin
          DCM_RST    <= 1'b0;
          DOMAIN_RST <= ALL1;
          LOCK_FAIL  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short cycle constants; expected
// values are hand-derived edge counts from reset release or SOFT_RST.
module tb_reset_sequencer;
  import rst_seq_pkg::*;

  localparam int NDCM = 2;
  localparam int NDOM = 3;

  logic            CLK         = 1'b0;
  logic            FORCE_RST_N = 1'b0;
  logic            SOFT_RST    = 1'b0;
  logic [NDCM-1:0] DCM_LOCKED  = '0;
  logic            DCM_RST;
  logic [NDOM-1:0] DOMAIN_RST;
  logic            LOCK_FAIL;
  logic            SEQ_DONE;
  state_t          STATE_DBG;

  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_exp;

  reset_sequencer #(
    .NUM_DCM             (NDCM),
    .NUM_DOMAINS         (NDOM),
    .CNT_W               (16),
    .DCM_RST_CYCLES      (8),
    .LOCK_TIMEOUT_CYCLES (20),
    .MAX_RETRIES         (1),
    .LOCK_SETTLE_CYCLES  (5),
    .STAGGER_CYCLES      (3)
  ) dut (
    .CLK         (CLK),
    .FORCE_RST_N (FORCE_RST_N),
    .SOFT_RST    (SOFT_RST),
    .DCM_LOCKED  (DCM_LOCKED),
    .DCM_RST     (DCM_RST),
    .DOMAIN_RST  (DOMAIN_RST),
    .LOCK_FAIL   (LOCK_FAIL),
    .SEQ_DONE    (SEQ_DONE),
    .STATE_DBG   (STATE_DBG)
  );

  // clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // advance n rising edges and settle 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // leaves FORCE_RST_N released just after an edge; the next edge is edge 1
  task automatic apply_reset(input logic [NDCM-1:0] lock);
    FORCE_RST_N = 1'b0;
    SOFT_RST    = 1'b0;
    DCM_LOCKED  = lock;
    tick(2);
    FORCE_RST_N = 1'b1;
  endtask

  initial begin
    // 1: normal bring-up, lock raised after edge 12
    apply_reset('0);
    check("rst_dcm_rst",   8'(DCM_RST),    8'h1);
    check("rst_domain",    8'(DOMAIN_RST), 8'h7);
    check("rst_lock_fail", 8'(LOCK_FAIL),  8'h0);
    check("rst_seq_done",  8'(SEQ_DONE),   8'h0);
    check("rst_state",     8'(STATE_DBG),  8'(ST_ASSERT_DCM));
    tick(7);
    check("t1_dcm_hi_e7", 8'(DCM_RST), 8'h1);
    tick(1);
    check("t1_dcm_lo_e8", 8'(DCM_RST),   8'h0);
    check("t1_wait_e8",   8'(STATE_DBG), 8'(ST_WAIT_LOCK));
    tick(4);
    DCM_LOCKED = '1;
    tick(2);
    check("t1_wait_e14", 8'(STATE_DBG), 8'(ST_WAIT_LOCK));
    tick(1);
    check("t1_settle_e15", 8'(STATE_DBG), 8'(ST_SETTLE));
    tick(4);
    check("t1_dom_e19", 8'(DOMAIN_RST), 8'h7);
    exp_q = '{8'h6, 8'h4, 8'h0};
    tick(1);
    last_exp = exp_q.pop_front();
    check("t1_rel_e20", 8'(DOMAIN_RST), last_exp);
    while (exp_q.size() > 0) begin
      tick(2);
      check("t1_rel_hold", 8'(DOMAIN_RST), last_exp);
      check("t1_done_lo",  8'(SEQ_DONE),   8'h0);
      tick(1);
      last_exp = exp_q.pop_front();
      check("t1_rel_step", 8'(DOMAIN_RST), last_exp);
    end
    check("t1_seq_done", 8'(SEQ_DONE),  8'h1);
    check("t1_run",      8'(STATE_DBG), 8'(ST_RUN));

    // 3: drop one lock bit in RUN
    DCM_LOCKED = 2'b01;
    tick(2);
    check("t3_dom_sync", 8'(DOMAIN_RST), 8'h0);
    tick(1);
    check("t3_dom_all",  8'(DOMAIN_RST), 8'h7);
    check("t3_dcm_rst",  8'(DCM_RST),    8'h1);
    check("t3_done_lo",  8'(SEQ_DONE),   8'h0);
    check("t3_state",    8'(STATE_DBG),  8'(ST_ASSERT_DCM));
    tick(7);
    check("t3_dcm_hi_last", 8'(DCM_RST), 8'h1);
    tick(1);
    check("t3_dcm_lo", 8'(DCM_RST), 8'h0);

    // 4: 2-cycle lock glitch in SETTLE
    apply_reset('0);
    tick(12);
    DCM_LOCKED = '1;
    tick(3);
    check("t4_settle_e15", 8'(STATE_DBG), 8'(ST_SETTLE));
    tick(1);
    DCM_LOCKED = '0;
    tick(2);
    DCM_LOCKED = '1;
    check("t4_settle_e18", 8'(STATE_DBG),  8'(ST_SETTLE));
    check("t4_dom_e18",    8'(DOMAIN_RST), 8'h7);
    tick(1);
    check("t4_wait_e19", 8'(STATE_DBG),  8'(ST_WAIT_LOCK));
    check("t4_dom_e19",  8'(DOMAIN_RST), 8'h7);
    tick(2);
    check("t4_settle_e21", 8'(STATE_DBG), 8'(ST_SETTLE));
    tick(4);
    check("t4_dom_e25", 8'(DOMAIN_RST), 8'h7);
    tick(1);
    check("t4_rel_e26", 8'(DOMAIN_RST), 8'h6);

    // 6: FORCE_RST_N while DOMAIN_RST=100
    tick(3);
    check("t6_dom_100", 8'(DOMAIN_RST), 8'h4);
    FORCE_RST_N = 1'b0;
    #1;
    check("t6_async_dom",  8'(DOMAIN_RST), 8'h7);
    check("t6_async_dcm",  8'(DCM_RST),    8'h1);
    check("t6_async_st",   8'(STATE_DBG),  8'(ST_ASSERT_DCM));
    tick(1);
    FORCE_RST_N = 1'b1;
    tick(7);
    check("t6_dcm_hi_e7", 8'(DCM_RST), 8'h1);
    tick(1);
    check("t6_dcm_lo_e8", 8'(DCM_RST), 8'h0);
    tick(1);
    check("t6_settle_e9", 8'(STATE_DBG), 8'(ST_SETTLE));
    tick(5);
    check("t6_rel_e14", 8'(DOMAIN_RST), 8'h6);
    tick(6);
    check("t6_rel_e20", 8'(DOMAIN_RST), 8'h0);
    check("t6_done",    8'(SEQ_DONE),   8'h1);

    // 2: lock never rises, one retry then FAIL
    apply_reset('0);
    tick(27);
    check("t2_wait_e27", 8'(STATE_DBG), 8'(ST_WAIT_LOCK));
    check("t2_dcm_e27",  8'(DCM_RST),   8'h0);
    tick(1);
    check("t2_retry_dcm", 8'(DCM_RST),   8'h1);
    check("t2_retry_st",  8'(STATE_DBG), 8'(ST_ASSERT_DCM));
    tick(8);
    check("t2_dcm_lo_e36", 8'(DCM_RST), 8'h0);
    tick(19);
    check("t2_nofail_e55", 8'(LOCK_FAIL), 8'h0);
    tick(1);
    check("t2_fail_flag", 8'(LOCK_FAIL),  8'h1);
    check("t2_fail_dom",  8'(DOMAIN_RST), 8'h7);
    check("t2_fail_dcm",  8'(DCM_RST),    8'h0);
    check("t2_fail_st",   8'(STATE_DBG),  8'(ST_FAIL));
    tick(5);
    check("t2_fail_sticky", 8'(LOCK_FAIL), 8'h1);

    // 5: SOFT_RST out of FAIL with lock held
    SOFT_RST   = 1'b1;
    DCM_LOCKED = '1;
    tick(1);
    SOFT_RST = 1'b0;
    check("t5_lock_fail_clr", 8'(LOCK_FAIL), 8'h0);
    check("t5_dcm_rst",       8'(DCM_RST),   8'h1);
    check("t5_state",         8'(STATE_DBG), 8'(ST_ASSERT_DCM));
    tick(7);
    check("t5_dcm_hi_last", 8'(DCM_RST), 8'h1);
    tick(1);
    check("t5_dcm_lo", 8'(DCM_RST), 8'h0);
    tick(1);
    check("t5_settle", 8'(STATE_DBG), 8'(ST_SETTLE));
    tick(5);
    check("t5_rel0", 8'(DOMAIN_RST), 8'h6);
    tick(3);
    check("t5_rel1", 8'(DOMAIN_RST), 8'h4);
    tick(3);
    check("t5_rel2", 8'(DOMAIN_RST), 8'h0);
    check("t5_done", 8'(SEQ_DONE),   8'h1);

    // SOFT_RST from RUN asserts everything on the next edge
    SOFT_RST = 1'b1;
    tick(1);
    SOFT_RST = 1'b0;
    check("soft_run_dom",  8'(DOMAIN_RST), 8'h7);
    check("soft_run_dcm",  8'(DCM_RST),    8'h1);
    check("soft_run_done", 8'(SEQ_DONE),   8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
